// File: rtl/spi_parity_tx.sv
// -----------------------------------------------------------------------------
// spi_parity_tx
//
// SPI controller-side frame transmitter with a trailing parity bit. A word is
// accepted over a valid/ready handshake and shifted out on PICO, MSB first:
// BUS_LENGTH data bits followed by one parity bit. In the same frame
// BUS_LENGTH+1 bits are captured from POCI, and their parity is checked.
//
// Frame sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE
//   SETUP : CS low, first bit on PICO, CLK_DIV cycles before the first SCK edge
//   SHIFT : 2*(BUS_LENGTH+1) SCK edges, CLK_DIV cycles apart
//   HOLD  : CLK_DIV cycles after the final edge, then CS rises
//   GAP   : CS_GAP cycles with CS high before the next word can be accepted
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   CPOL, CPHA    in   SPI mode, latched when a word is accepted
//   tx_valid      in   tx_data holds a word to send
//   tx_ready      out  block can accept a word (IDLE and not in reset)
//   tx_data       in   word to send
//   POCI          in   peripheral-out serial data
//   SCK           out  serial clock
//   CS            out  chip select, active low
//   PICO          out  controller-out serial data
//   rx_valid      out  one-cycle pulse when rx_data / rx_parity_err update
//   rx_data       out  received data bits, MSB first
//   rx_parity_err out  received parity bit disagrees with received data
//   busy          out  high in every state except IDLE
// -----------------------------------------------------------------------------
module spi_parity_tx #(
    parameter int BUS_LENGTH = 8,
    parameter int CLK_DIV    = 4,
    parameter bit ODD_PARITY = 1'b0,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [BUS_LENGTH-1:0] tx_data,
    input  logic                  POCI,
    output logic                  SCK,
    output logic                  CS,
    output logic                  PICO,
    output logic                  rx_valid,
    output logic [BUS_LENGTH-1:0] rx_data,
    output logic                  rx_parity_err,
    output logic                  busy
);

    localparam int N       = BUS_LENGTH + 1;
    localparam int EDGES   = 2 * N;
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EDGE_W  = $clog2(EDGES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;        // cycles spent in the current SCK slot / gap
    logic [EDGE_W-1:0]   edge_cnt;   // SCK edges already produced this frame
    logic [EDGE_W-1:0]   edge_num;   // number of the edge about to be produced
    logic                cpol_q;
    logic                cpha_q;
    logic [N-1:0]        tx_shift;   // MSB is the bit currently on PICO
    logic [N-1:0]        rx_shift;

    logic                accept;
    logic                div_tick;
    logic                gap_done;
    logic                sck_edge;
    logic                frame_done;
    logic                is_lead;
    logic                do_sample;
    logic                do_advance;
    logic                tx_parity;
    logic                rx_parity;

    assign tx_ready  = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign PICO      = tx_shift[N-1];

    assign tx_parity = (^tx_data) ^ ODD_PARITY;
    assign rx_parity = (^rx_shift[N-1:1]) ^ ODD_PARITY;

    assign div_tick  = (cnt == CNT_W'(CLK_DIV - 1));
    assign gap_done  = (cnt == CNT_W'(CS_GAP - 1));

    // Edges are numbered from 1: odd numbers are leading edges (away from
    // CPOL), even numbers trailing. The sampling edge is the leading one for
    // CPHA=0 and the trailing one for CPHA=1; PICO advances on the other kind,
    // except on edge 1 (the first bit is already on PICO from SETUP) and on
    // the final edge (the parity bit stays until the frame ends).
    assign edge_num   = edge_cnt + EDGE_W'(1);
    assign is_lead    = edge_num[0];
    assign do_sample  = is_lead ^ cpha_q;
    assign do_advance = !do_sample
                        && (edge_num != EDGE_W'(1))
                        && (edge_num != EDGE_W'(EDGES));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control strobes
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sck_edge   = 1'b0;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (div_tick) begin
                    sck_edge   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (div_tick) begin
                    sck_edge = 1'b1;
                    if (edge_num == EDGE_W'(EDGES)) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (div_tick) begin
                    frame_done = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: timing counter, pins, shift registers, receive results
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            edge_cnt      <= '0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            SCK           <= 1'b0;
            CS            <= 1'b1;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            // The counter restarts at every state change and every SCK edge,
            // so it always measures cycles since the last timing event.
            if (state == IDLE || state_next != state || sck_edge) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // While idle, SCK tracks the live CPOL so the bus idles correctly
            // even before the first word arrives.
            if (state == IDLE) begin
                SCK <= CPOL;
            end

            if (accept) begin
                cpol_q   <= CPOL;
                cpha_q   <= CPHA;
                tx_shift <= {tx_data, tx_parity};
                rx_shift <= '0;
                edge_cnt <= '0;
                CS       <= 1'b0;
            end

            if (sck_edge) begin
                edge_cnt <= edge_num;
                SCK      <= is_lead ? ~cpol_q : cpol_q;
                // POCI is captured on the clk edge that moves SCK to the
                // sampling level.
                if (do_sample) begin
                    rx_shift <= {rx_shift[N-2:0], POCI};
                end
                if (do_advance) begin
                    tx_shift <= {tx_shift[N-2:0], 1'b0};
                end
            end

            if (frame_done) begin
                CS            <= 1'b1;
                rx_valid      <= 1'b1;
                rx_data       <= rx_shift[N-1:1];
                rx_parity_err <= (rx_parity != rx_shift[0]);
            end
        end
    end

endmodule

// File: tb/tb_spi_parity_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_parity_tx
//
// Self-checking bench for spi_parity_tx. The reference model works at the
// bus level: the expected PICO frame is the data word followed by its parity
// bit, the responder presents a chosen 9-bit word one bit per sampling edge,
// and expected receive results follow from the parity rule. A second instance
// with ODD_PARITY=1 covers the odd-parity setting.
// -----------------------------------------------------------------------------
module tb_spi_parity_tx;

    localparam int BL = 8;

    logic          clk;
    logic          rst;
    logic          cpol;
    logic          cpha;
    logic          tx_valid;
    logic          tx_ready;
    logic [BL-1:0] tx_data;
    logic          poci;
    logic          poci_drv;
    logic          loop;
    logic          sck;
    logic          cs;
    logic          pico;
    logic          rx_valid;
    logic [BL-1:0] rx_data;
    logic          rx_parity_err;
    logic          busy;

    // Odd-parity instance, mode 0, permanent loopback
    logic          tx_valid_o;
    logic          tx_ready_o;
    logic [BL-1:0] tx_data_o;
    logic          sck_o;
    logic          cs_o;
    logic          pico_o;
    logic          rx_valid_o;
    logic [BL-1:0] rx_data_o;
    logic          rx_err_o;
    logic          busy_o;

    int n_cmp;
    int n_fail;

    assign poci = loop ? pico : poci_drv;

    spi_parity_tx #(.BUS_LENGTH(BL), .CLK_DIV(4), .ODD_PARITY(1'b0), .CS_GAP(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .CPOL          (cpol),
        .CPHA          (cpha),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .POCI          (poci),
        .SCK           (sck),
        .CS            (cs),
        .PICO          (pico),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .busy          (busy)
    );

    spi_parity_tx #(.BUS_LENGTH(BL), .CLK_DIV(4), .ODD_PARITY(1'b1), .CS_GAP(2)) dut_odd (
        .clk           (clk),
        .rst           (rst),
        .CPOL          (1'b0),
        .CPHA          (1'b0),
        .tx_valid      (tx_valid_o),
        .tx_ready      (tx_ready_o),
        .tx_data       (tx_data_o),
        .POCI          (pico_o),
        .SCK           (sck_o),
        .CS            (cs_o),
        .PICO          (pico_o),
        .rx_valid      (rx_valid_o),
        .rx_data       (rx_data_o),
        .rx_parity_err (rx_err_o),
        .busy          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One frame on the even-parity instance. lb=1 loops PICO back to POCI;
    // otherwise the responder shifts out resp MSB first, one bit per
    // sampling edge. Mid-frame the bench perturbs tx_data, CPOL and CPHA to
    // confirm they are ignored until the next acceptance.
    task automatic run_frame(input logic [BL-1:0] data, input logic m_cpol, input logic m_cpha,
                             input logic lb, input logic [BL:0] resp, input string tag);
        logic [BL:0]   exp_frame;
        logic [BL:0]   got_bits;
        logic [BL-1:0] exp_rx;
        logic          exp_err;
        logic [BL-1:0] got_rx;
        logic          got_err;
        logic          prev_sck;
        logic          is_lead;
        logic          done;
        logic          seen_low;
        int            nsamp, nedge, cs_low, nvalid, ctrl_bad, extra_valid;

        exp_frame = {data, ^data};
        exp_rx    = lb ? data : resp[BL:1];
        exp_err   = lb ? 1'b0 : ((^resp[BL:1]) != resp[0]);
        got_bits  = '0;
        got_rx    = '0;
        got_err   = 1'b0;
        nsamp = 0; nedge = 0; cs_low = 0; nvalid = 0; ctrl_bad = 0; extra_valid = 0;
        done = 1'b0; seen_low = 1'b0;

        @(negedge clk);
        cpol = m_cpol; cpha = m_cpha; loop = lb; poci_drv = resp[BL];
        tx_data = data; tx_valid = 1'b0;
        @(negedge clk);
        check({tag, "_idle_sck"}, sck, m_cpol);
        check({tag, "_ready"}, tx_ready, 1'b1);
        tx_valid = 1'b1;
        prev_sck = sck;

        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (tx_valid && !cs) begin
                tx_valid = 1'b0;
                tx_data  = ~data;
                cpol     = ~m_cpol;
                cpha     = ~m_cpha;
            end
            if (!cs) begin
                seen_low = 1'b1;
                cs_low++;
                if (busy !== 1'b1 || tx_ready !== 1'b0) ctrl_bad++;
            end
            if (!cs && sck !== prev_sck) begin
                nedge++;
                is_lead = (sck !== m_cpol);
                if (is_lead != m_cpha) begin
                    if (nsamp <= BL) got_bits[BL-nsamp] = pico;
                    nsamp++;
                    if (nsamp <= BL) poci_drv = resp[BL-nsamp];
                end
            end
            prev_sck = sck;
            if (rx_valid) begin
                nvalid++;
                got_rx  = rx_data;
                got_err = rx_parity_err;
            end
            if (seen_low && cs) done = 1'b1;
        end

        check({tag, "_done"}, done, 1'b1);
        check({tag, "_end_sck"}, sck, m_cpol);
        cpol = m_cpol;
        cpha = m_cpha;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rx_valid) extra_valid++;
        end

        check({tag, "_cs_low"}, cs_low, 76);
        check({tag, "_edges"}, nedge, 18);
        check({tag, "_samples"}, nsamp, BL + 1);
        check({tag, "_pico_bits"}, got_bits, exp_frame);
        check({tag, "_rx_valid"}, nvalid + extra_valid, 1);
        check({tag, "_rx_data"}, got_rx, exp_rx);
        check({tag, "_rx_err"}, got_err, exp_err);
        check({tag, "_ctrl"}, ctrl_bad, 0);
        check({tag, "_hold_data"}, rx_data, exp_rx);
    endtask

    // Odd-parity instance: data 0x00 must be followed by a parity bit of 1.
    task automatic run_odd();
        logic [BL:0]   bits;
        logic [BL-1:0] rxd;
        logic          err;
        logic          prev;
        logic          done;
        logic          seen_low;
        int            n, nvalid;

        bits = '0; rxd = '1; err = 1'b1; n = 0; nvalid = 0;
        done = 1'b0; seen_low = 1'b0;
        @(negedge clk);
        tx_data_o  = 8'h00;
        tx_valid_o = 1'b1;
        prev = sck_o;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (tx_valid_o && !cs_o) tx_valid_o = 1'b0;
            if (!cs_o) seen_low = 1'b1;
            if (!cs_o && sck_o && !prev) begin
                if (n <= BL) bits[BL-n] = pico_o;
                n++;
            end
            prev = sck_o;
            if (rx_valid_o) begin
                nvalid++;
                rxd = rx_data_o;
                err = rx_err_o;
            end
            if (seen_low && cs_o) done = 1'b1;
        end
        check("odd_done", done, 1'b1);
        check("odd_samples", n, BL + 1);
        check("odd_ninth_bit", bits[0], 1'b1);
        check("odd_frame", bits, {8'h00, 1'b1});
        check("odd_rx_valid", nvalid, 1);
        check("odd_rx_data", rxd, 8'h00);
        check("odd_rx_err", err, 1'b0);
    endtask

    // tx_valid held high: 0x11 then 0x22 go out back-to-back.
    task automatic run_back_to_back();
        logic [BL:0] got[$];
        logic        prev_cs;
        int          nfall, nrise, gap, rdy_bad;

        nfall = 0; nrise = 0; gap = 0; rdy_bad = 0;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; loop = 1'b1;
        tx_data = 8'h11; tx_valid = 1'b1;
        prev_cs = cs;
        for (int cyc = 0; cyc < 400 && nrise < 2; cyc++) begin
            @(negedge clk);
            if (prev_cs && !cs) begin
                nfall++;
                if (nfall == 1) begin
                    tx_data = 8'h22;
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'hFF;
                end
            end
            if (!prev_cs && cs) nrise++;
            if (!cs && tx_ready) rdy_bad++;
            if (cs && nfall == 1 && nrise == 1) gap++;
            if (rx_valid) got.push_back({rx_parity_err, rx_data});
            prev_cs = cs;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (prev_cs && !cs) nfall++;
            if (rx_valid) got.push_back({rx_parity_err, rx_data});
            prev_cs = cs;
        end
        check("b2b_frames", nfall, 2);
        check("b2b_ends", nrise, 2);
        check("b2b_gap", gap, 3);
        check("b2b_ready_low", rdy_bad, 0);
        check("b2b_n_valid", got.size(), 2);
        while (got.size() < 2) got.push_back('1);
        check("b2b_first", got[0], {1'b0, 8'h11});
        check("b2b_second", got[1], {1'b0, 8'h22});
    endtask

    // Reset during the 5th bit of 0xC3 (mode 2 so the SCK reset level differs
    // from the idle level), then a clean frame of 0xB6.
    task automatic run_reset_mid();
        logic prev_sck;
        logic reached;
        int   nsamp, stray_valid, stray_cs;

        nsamp = 0; reached = 1'b0; stray_valid = 0; stray_cs = 0;
        @(negedge clk);
        cpol = 1'b1; cpha = 1'b0; loop = 1'b1;
        tx_data = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b1;
        prev_sck = sck;
        for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
            @(negedge clk);
            if (tx_valid && !cs) tx_valid = 1'b0;
            if (!cs && sck !== prev_sck && sck !== cpol) nsamp++;
            prev_sck = sck;
            if (nsamp == 5) reached = 1'b1;
        end
        check("rst_reached_bit5", reached, 1'b1);
        tx_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_cs", cs, 1'b1);
        check("rst_mid_sck", sck, 1'b0);
        check("rst_mid_pico", pico, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_rx_data", rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_valid) stray_valid++;
            if (!cs) stray_cs++;
        end
        check("rst_no_rx_valid", stray_valid, 0);
        check("rst_no_cs", stray_cs, 0);
        run_frame(8'hB6, 1'b0, 1'b0, 1'b1, '0, "after_rst");
    endtask

    initial begin
        logic [BL-1:0] r_data;
        logic [BL:0]   r_resp;
        logic          r_cpol, r_cpha, r_lb;

        n_cmp = 0; n_fail = 0;
        rst = 1'b1;
        cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b0; tx_data = '0;
        poci_drv = 1'b0; loop = 1'b1;
        tx_valid_o = 1'b0; tx_data_o = '0;

        repeat (3) @(negedge clk);
        check("reset_cs", cs, 1'b1);
        check("reset_sck", sck, 1'b0);
        check("reset_pico", pico, 1'b0);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_err", rx_parity_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_tx_ready", tx_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", tx_ready, 1'b1);

        run_frame(8'hA5, 1'b0, 1'b0, 1'b1, '0, "m0_a5");
        run_frame(8'h07, 1'b0, 1'b1, 1'b1, '0, "m1_07");
        run_frame(8'h07, 1'b1, 1'b0, 1'b1, '0, "m2_07");
        run_frame(8'h07, 1'b1, 1'b1, 1'b1, '0, "m3_07");
        run_odd();
        run_frame(8'h3C, 1'b0, 1'b0, 1'b0, {8'h5A, 1'b1}, "resp_bad_par");
        run_back_to_back();
        run_reset_mid();

        for (int i = 0; i < 8; i++) begin
            r_data = BL'($urandom);
            r_resp = (BL + 1)'($urandom);
            r_cpol = 1'($urandom);
            r_cpha = 1'($urandom);
            r_lb   = 1'($urandom);
            run_frame(r_data, r_cpol, r_cpha, r_lb, r_resp, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
